// File: rtl/halfword_unload.sv
// Parallel-in, serial-out halfword unloader. One load handshake captures a
// frame of LENGTH halfwords, which then leave oldest-first (in[LENGTH-1] .. in0).
module halfword_unload #(
  parameter int LENGTH = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  input  logic [15:0] in8,
  input  logic [15:0] in9,
  input  logic [15:0] in10,
  input  logic [15:0] in11,
  input  logic [15:0] in12,
  input  logic [15:0] in13,
  input  logic [15:0] in14,
  input  logic [15:0] in15,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LENGTH - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] buf_q [16];
  logic [15:0] in_w  [16];
  logic        load_acc;
  logic        beat_acc;

  assign in_w[0]  = in0;
  assign in_w[1]  = in1;
  assign in_w[2]  = in2;
  assign in_w[3]  = in3;
  assign in_w[4]  = in4;
  assign in_w[5]  = in5;
  assign in_w[6]  = in6;
  assign in_w[7]  = in7;
  assign in_w[8]  = in8;
  assign in_w[9]  = in9;
  assign in_w[10] = in10;
  assign in_w[11] = in11;
  assign in_w[12] = in12;
  assign in_w[13] = in13;
  assign in_w[14] = in14;
  assign in_w[15] = in15;

  // rstb gates load_ready so the bank never sees a ready while we are held in reset.
  always_comb begin
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = 16'h0000;
    out_last   = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = buf_q[idx_q];
      out_last  = (idx_q == 4'd0);
      load_ready = rstb & (idx_q == 4'd0) & out_ready;
    end else begin
      load_ready = rstb;
    end
  end

  assign load_acc = load_valid & load_ready;
  assign beat_acc = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_acc) begin
      state_d = SEND;
      idx_d   = LAST_IDX;
    end else if (beat_acc) begin
      if (idx_q != 4'd0) begin
        idx_d = idx_q - 4'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_acc) begin
        for (int k = 0; k < 16; k++) begin
          buf_q[k] <= in_w[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_halfword_unload.sv
// Scoreboard bench for halfword_unload: a LENGTH=16 instance with a shift-loader
// model on its output, plus a LENGTH=1 instance. State changes on falling edges.
module tb_halfword_unload;

  logic        clk;
  logic        rstb;
  logic        load_valid, out_ready;
  logic        load_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic        lv1, or1;
  logic        lr1, ov1, last1;
  logic [15:0] d1;
  logic [15:0] din [16];
  logic [15:0] ld  [16];
  logic [16:0] sb [$];
  int          checks;
  int          errors;

  halfword_unload #(.LENGTH(16)) u_dut (
    .clk(clk), .rstb(rstb), .load_valid(load_valid), .load_ready(load_ready),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .in8(din[8]), .in9(din[9]), .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  halfword_unload #(.LENGTH(1)) u_one (
    .clk(clk), .rstb(rstb), .load_valid(lv1), .load_ready(lr1),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .in8(din[8]), .in9(din[9]), .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .out_valid(ov1), .out_ready(or1), .out_data(d1), .out_last(last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven at rising edges; this samples what the next falling edge will use.
  always begin
    logic [16:0] exp;
    @(posedge clk);
    #1;
    if (rstb === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got data=%h last=%b", out_data, out_last);
      end else begin
        exp = sb.pop_front();
        if ({out_last, out_data} !== exp) begin
          errors++;
          $display("FAIL sb_beat got data=%h last=%b want data=%h last=%b",
                   out_data, out_last, exp[15:0], exp[16]);
        end
      end
      for (int k = 15; k > 0; k--) ld[k] = ld[k-1];
      ld[0] = out_data;
    end
  end

  task automatic set_frame(input logic [15:0] base);
    for (int k = 0; k < 16; k++) din[k] = base + 16'(k);
  endtask

  // Presents a frame on an idle unloader and records its expected emission order.
  task automatic start_load(input logic [15:0] base);
    @(posedge clk);
    set_frame(base);
    load_valid = 1'b1;
    out_ready  = 1'b1;
    #1;
    for (int i = 15; i >= 0; i--) sb.push_back({(i == 0), din[i]});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (out_valid === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout out_valid=%b want 0", name, out_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b0;
    lv1 = 1'b0;
    or1 = 1'b0;
    set_frame(16'h0000);
    for (int k = 0; k < 16; k++) ld[k] = 16'h0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, out_data, load_ready} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h lr=%b want all 0",
               out_valid, out_last, out_data, load_ready);
    end
    rstb = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got lr=%b v=%b want lr=1 v=0", load_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    start_load(16'h1000);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_load_ready got %b want 1", load_ready);
    end
    @(posedge clk);
    load_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h100F) begin
      errors++;
      $display("FAIL basic_latency got v=%b d=%h want v=1 d=100f", out_valid, out_data);
    end
    n = 0;
    repeat (20) begin
      if (out_valid === 1'b1) n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL basic_valid_cycles got %0d want 16", n);
    end
    wait_idle("basic");
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ld[k] !== 16'h1000 + 16'(k)) begin
        errors++;
        $display("FAIL roundtrip_out%0d got %h want %h", k, ld[k], 16'h1000 + 16'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    start_load(16'h1000);
    @(posedge clk);
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h100B || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b d=%h l=%b want v=1 d=100b l=0",
                 s, out_valid, out_data, out_last);
      end
    end
    @(posedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_data !== 16'h100B) begin
      errors++;
      $display("FAIL stall_resume got %h want 100b", out_data);
    end
    wait_idle("stall");
  endtask

  task automatic test_back_to_back();
    start_load(16'h1000);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      load_valid = 1'b0;
      if (k >= 14) begin
        set_frame(16'h2000);
        load_valid = 1'b1;
      end
      #1;
      if (k == 14 || k == 15) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early_ready k=%0d got %b want 0", k, load_ready);
        end
      end
    end
    checks++;
    if (load_ready !== 1'b1 || out_last !== 1'b1 || out_data !== 16'h1000) begin
      errors++;
      $display("FAIL b2b_last got lr=%b l=%b d=%h want lr=1 l=1 d=1000",
               load_ready, out_last, out_data);
    end
    for (int i = 15; i >= 0; i--) sb.push_back({(i == 0), din[i]});
    @(posedge clk);
    load_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h200F || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble got v=%b d=%h lr=%b want v=1 d=200f lr=0",
               out_valid, out_data, load_ready);
    end
    wait_idle("b2b");
  endtask

  task automatic test_load_ignored();
    start_load(16'h3000);
    @(posedge clk);
    load_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      set_frame(16'h4000);
      load_valid = 1'b1;
      #1;
      checks++;
      if (load_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignored_ready k=%0d got %b want 0", k, load_ready);
      end
    end
    @(posedge clk);
    load_valid = 1'b0;
    wait_idle("ignored");
  endtask

  task automatic test_reset_mid();
    start_load(16'h5000);
    @(posedge clk);
    load_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, load_ready} !== 19'h0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b l=%b d=%h lr=%b want all 0",
               out_valid, out_last, out_data, load_ready);
    end
    sb.delete();
    @(posedge clk);
    rstb = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got lr=%b v=%b want lr=1 v=0", load_ready, out_valid);
    end
    start_load(16'h6000);
    @(posedge clk);
    load_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 16'h600F) begin
      errors++;
      $display("FAIL midreset_fresh got %h want 600f", out_data);
    end
    wait_idle("midreset");
  endtask

  task automatic test_length_one();
    @(posedge clk);
    set_frame(16'h1100);
    din[0] = 16'hBEEF;
    lv1 = 1'b1;
    or1 = 1'b1;
    #1;
    checks++;
    if (lr1 !== 1'b1) begin
      errors++;
      $display("FAIL one_ready got %b want 1", lr1);
    end
    @(posedge clk);
    lv1 = 1'b0;
    #1;
    checks++;
    if (ov1 !== 1'b1 || d1 !== 16'hBEEF || last1 !== 1'b1) begin
      errors++;
      $display("FAIL one_beat got v=%b d=%h l=%b want v=1 d=beef l=1", ov1, d1, last1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("FAIL one_single got v=%b d=%h want v=0", ov1, d1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_load_ignored();
    test_reset_mid();
    test_length_one();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/halfword_unload.md
# halfword_unload

Parallel-in, serial-out halfword unloader: the transmit-side counterpart of the 16-deep halfword shift loader. On one load handshake it captures up to 16 parallel halfwords, then emits them one per accepted beat on a valid/ready stream. Words leave oldest-first, so a loader fed from this stream reproduces the original parallel image. It sits between a parallel result bank and any serial halfword consumer.

## Interface
- LENGTH, 16, halfwords per frame (1..16); emitted words are in[LENGTH-1] down to in0
- clk  in  1  clock; all state updates on the falling edge
- rstb  in  1  asynchronous active-low reset
- load_valid  in  1  parallel frame present on in0..in15
- load_ready  out  1  unloader accepts a frame this edge
- in0 .. in15  in  16 each  parallel halfwords; in[k] for k >= LENGTH ignored
- out_valid  out  1  out_data holds a valid halfword
- out_ready  in  1  consumer accepts out_data this edge
- out_data  out  16  current halfword
- out_last  out  1  current halfword is the final word of the frame (in0)

## Operation
- Storage: 16x16 frame buffer, 4-bit index idx, FSM {IDLE, SEND}.
- Load accept at a falling edge when load_valid & load_ready: buffer <= in0..in15, idx <= LENGTH-1, state <= SEND.
- IDLE: load_ready = 1, out_valid = 0, out_last = 0.
- SEND: out_valid = 1, out_data = buffer[idx], out_last = (idx == 0).
- Beat accept at a falling edge when out_valid & out_ready:
  - idx != 0: idx <= idx - 1, stay SEND.
  - idx == 0 and no load accepted the same edge: state <= IDLE.
  - idx == 0 and load accepted the same edge: reload buffer, idx <= LENGTH-1, stay SEND (back-to-back frames, no bubble).
- load_ready = IDLE | (SEND & idx == 0 & out_ready). This is the only combinational path from out_ready to load_ready. In SEND with idx != 0, load_ready = 0 and load_valid is ignored.
- Backpressure: while out_valid & !out_ready, out_data, out_last and idx hold unchanged.
- in0..in15 are sampled only at a load-accept edge; later changes have no effect on the frame in flight.
- LENGTH = 1: every beat has out_last = 1, and each frame is one word, in0.
- Round trip: frame words in emission order are in[LENGTH-1], ..., in1, in0. Shifted through a LENGTH-deep loader, they land with out_k == in_k.

## Timing
- Reset (rstb low, asynchronous): state IDLE, idx 0, buffer all 0. Outputs: out_valid 0, out_data 0x0000, out_last 0, load_ready 0. load_ready goes to 1 once rstb is high.
- Reset mid-frame: the frame is dropped immediately. No resume after reset.
- Latency: the load-accept edge E makes out_valid 1 and out_data = in[LENGTH-1] right after E.
- Throughput: with out_ready held high, one word per cycle; a frame occupies exactly LENGTH cycles of out_valid.
- Back-to-back: the next frame's first word follows the previous out_last beat with zero idle cycles.
- All handshake inputs are sampled at the falling edge of clk. Outputs change only after falling edges, except load_ready, which tracks out_ready combinationally in the last-word state.

## Test plan
- Reset, then load in_k = 0x1000+k with LENGTH=16 and out_ready=1 -> out_data 0x100F, 0x100E, ..., 0x1000 on 16 consecutive edges; out_last only on 0x1000; then IDLE with out_valid=0.
- Backpressure: same frame, out_ready low for 3 cycles on the 5th word (0x100B) -> 0x100B holds stable with out_valid=1; sequence resumes without loss or duplication.
- Back-to-back: second frame in_k = 0x2000+k presented with load_valid during the 0x1000 beat -> 0x200F follows 0x1000 on the next cycle with no bubble; load_ready=1 only on that edge.
- Load ignored: load_valid asserted with different data while idx != 0 -> load_ready=0 and the current frame is unchanged.
- Async reset asserted mid-frame after 7 beats -> out_valid, out_data and out_last go to 0 immediately; after release, a fresh load emits from in15 again.
- LENGTH=1 build: load in0=0xBEEF -> a single beat 0xBEEF with out_last=1; in1..in15 never appear. Also loop the LENGTH=16 output into the 16-deep loader and check out_k == in_k.
